cgra_pe_out_stream: RTL and testbench

- Parametrised next-generation output-PE back end for the CGRA.
- Accepts the ALU result stream tagged with a thread index and applies per-thread ignore (skip first N) and quantity (emit exactly Q) filtering.
- Buffers surviving words in an internal FIFO with a valid/ready output, flags the last word per thread, and raises an almost-full stall toward the PE array.
- Replaces the fixed 8-thread, unbuffered, write-enable-only output path.

---
 rtl/cgra_pe_out_stream.sv | 149 ++++++++++++++
 tb/tb_cgra_pe_out_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cgra_pe_out_stream.sv
// CGRA output-PE back end: per-thread ignore/quantity filtering of the ALU result
// stream, a first-word-fall-through FIFO with valid/ready output, and an almost-full stall.
module cgra_pe_out_stream #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_THREADS  = 8,
    parameter int THREAD_W     = 3,
    parameter int IGN_WIDTH    = 16,
    parameter int QTD_WIDTH    = 64,
    parameter int FIFO_AW      = 4,
    parameter int STALL_MARGIN = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_in_valid,
    input  logic [THREAD_W-1:0]    i_in_thread,
    input  logic [DATA_WIDTH-1:0]  i_in_data,
    input  logic                   i_cfg_we,
    input  logic                   i_cfg_sel,
    input  logic [THREAD_W-1:0]    i_cfg_thread,
    input  logic [QTD_WIDTH-1:0]   i_cfg_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [DATA_WIDTH-1:0]  o_out_data,
    output logic [THREAD_W-1:0]    o_out_thread,
    output logic                   o_out_last,
    output logic                   o_stall,
    output logic [NUM_THREADS-1:0] o_done,
    output logic                   o_all_done,
    output logic                   o_overflow
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef struct packed {
        logic                  last;
        logic [THREAD_W-1:0]   thread;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [IGN_WIDTH-1:0]   r_ign_lim [NUM_THREADS];
    logic [IGN_WIDTH-1:0]   r_ign_cnt [NUM_THREADS];
    logic [QTD_WIDTH-1:0]   r_qtd_lim [NUM_THREADS];
    logic [QTD_WIDTH-1:0]   r_qtd_cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0] r_armed;

    entry_t                 r_mem [DEPTH];
    logic [FIFO_AW-1:0]     r_wr_ptr;
    logic [FIFO_AW-1:0]     r_rd_ptr;
    logic [FIFO_AW:0]       r_count;
    logic                   r_overflow;

    logic [NUM_THREADS-1:0] w_done;
    logic [NUM_THREADS-1:0] w_cfg_hit;
    logic [NUM_THREADS-1:0] w_skip;
    logic [NUM_THREADS-1:0] w_acc_t;
    logic                   w_acc;
    logic                   w_last;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic [31:0]            w_free;
    entry_t                 w_head;

    // A config write to a thread masks that thread's same-cycle input entirely.
    always_comb begin
        w_done    = '0;
        w_cfg_hit = '0;
        w_skip    = '0;
        w_acc_t   = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_done[t]    = r_armed[t] && (r_qtd_cnt[t] == r_qtd_lim[t]);
            w_cfg_hit[t] = i_cfg_we && (i_cfg_thread == THREAD_W'(t));
            if (i_en && i_in_valid && (i_in_thread == THREAD_W'(t)) && !w_cfg_hit[t]
                && r_armed[t] && !w_done[t]) begin
                w_skip[t]  = r_ign_cnt[t] < r_ign_lim[t];
                w_acc_t[t] = !(r_ign_cnt[t] < r_ign_lim[t]);
            end
        end
    end

    assign w_acc  = |w_acc_t;
    assign w_last = (r_qtd_cnt[i_in_thread] + QTD_WIDTH'(1)) == r_qtd_lim[i_in_thread];
    assign w_full = r_count == (FIFO_AW+1)'(DEPTH);
    assign w_pop  = o_out_valid && i_out_ready;
    assign w_push = w_acc && (!w_full || w_pop);
    assign w_free = 32'(DEPTH) - 32'(r_count);
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_armed <= '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_ign_lim[t] <= '0;
                r_ign_cnt[t] <= '0;
                r_qtd_lim[t] <= '0;
                r_qtd_cnt[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_cfg_hit[t]) begin
                    r_ign_cnt[t] <= '0;
                    if (!i_cfg_sel) begin
                        r_ign_lim[t] <= i_cfg_data[IGN_WIDTH-1:0];
                    end else begin
                        r_qtd_lim[t] <= i_cfg_data;
                        r_qtd_cnt[t] <= '0;
                        r_armed[t]   <= 1'b1;
                    end
                end else if (w_skip[t]) begin
                    r_ign_cnt[t] <= r_ign_cnt[t] + IGN_WIDTH'(1);
                end else if (w_acc_t[t]) begin
                    // Advances even when the word is lost to a full FIFO.
                    r_qtd_cnt[t] <= r_qtd_cnt[t] + QTD_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_acc && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{last: w_last, thread: i_in_thread, data: i_in_data};
    end

    assign o_out_valid  = r_count != '0;
    assign o_out_data   = w_head.data;
    assign o_out_thread = w_head.thread;
    assign o_out_last   = w_head.last;
    assign o_stall      = w_free <= 32'(STALL_MARGIN);
    assign o_done       = w_done;
    assign o_all_done   = (|r_armed) && (&(w_done | ~r_armed)) && (r_count == '0);
    assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_cgra_pe_out_stream.sv
// Directed bench for cgra_pe_out_stream: filtering, FIFO fill/overflow, stall and reset.
module tb_cgra_pe_out_stream;
    localparam int DW = 16, NT = 8, TW = 3, IW = 16, QW = 64, AW = 4, SM = 4;

    logic          clk = 1'b0;
    logic          rst, en, in_valid, cfg_we, cfg_sel, out_ready;
    logic [TW-1:0] in_thread, cfg_thread;
    logic [DW-1:0] in_data;
    logic [QW-1:0] cfg_data;
    logic          out_valid, out_last, stall, all_done, overflow;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_thread;
    logic [NT-1:0] done;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] cap_d[$];
    logic          cap_l[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];

    cgra_pe_out_stream #(
        .DATA_WIDTH(DW), .NUM_THREADS(NT), .THREAD_W(TW), .IGN_WIDTH(IW),
        .QTD_WIDTH(QW), .FIFO_AW(AW), .STALL_MARGIN(SM)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_in_valid(in_valid),
        .i_in_thread(in_thread), .i_in_data(in_data), .i_cfg_we(cfg_we),
        .i_cfg_sel(cfg_sel), .i_cfg_thread(cfg_thread), .i_cfg_data(cfg_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_thread(out_thread), .o_out_last(out_last), .o_stall(stall),
        .o_done(done), .o_all_done(all_done), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Heads are captured at the negedge, when out_ready for the coming edge is settled.
    task automatic tick();
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            cap_d.push_back(out_data);
            cap_l.push_back(out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg(input int th, input logic sel, input logic [63:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_thread = TW'(th); cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic feed(input int th, input logic [DW-1:0] d);
        en = 1'b1; in_valid = 1'b1; in_thread = TW'(th); in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_caps(input string tag);
        chk({tag, "_count"}, 64'(cap_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(cap_d[i]), 64'(exp_d[i]));
            chk($sformatf("%s_last%0d", tag, i), 64'(cap_l[i]), 64'(exp_l[i]));
        end
        cap_d.delete(); cap_l.delete(); exp_d.delete(); exp_l.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_thread = '0; in_data = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_thread = '0; cfg_data = '0; out_ready = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stall",     64'(stall),     64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_all_done",  64'(all_done),  64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        cap_d.delete(); cap_l.delete();

        // Thread 2: skip 3, emit 4 of 10..19.
        cfg(2, 1'b0, 64'd3);
        cfg(2, 1'b1, 64'd4);
        out_ready = 1'b1;
        for (int v = 10; v < 20; v++) begin
            feed(2, DW'(v));
            if (v == 15) chk("t1_done_before16", 64'(done[2]), 64'd0);
            if (v == 16) chk("t1_done_at16",     64'(done[2]), 64'd1);
        end
        idle(3);
        exp_d = '{16'd13, 16'd14, 16'd15, 16'd16};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        chk_caps("t1");
        chk("t1_done",     64'(done),     64'h04);
        chk("t1_all_done", 64'(all_done), 64'd1);

        // Unarmed thread 5 produces nothing.
        for (int i = 0; i < 4; i++) feed(5, DW'(50 + i));
        idle(2);
        chk_caps("t2");
        chk("t2_done",     64'(done),     64'h04);
        chk("t2_all_done", 64'(all_done), 64'd1);

        // qtd=0 on thread 1: done next cycle, inputs swallowed.
        cfg(1, 1'b1, 64'd0);
        chk("t3_done", 64'(done), 64'h06);
        for (int i = 0; i < 3; i++) feed(1, DW'(60 + i));
        idle(2);
        chk_caps("t3");
        chk("t3_all_done", 64'(all_done), 64'd1);

        // Thread 3 qtd=19: fill, stall, full push+pop, overflow, then last word.
        out_ready = 1'b0;
        cfg(3, 1'b1, 64'd19);
        for (int i = 0; i < 16; i++) begin
            feed(3, DW'(100 + i));
            if (i == 10) chk("t4_stall_at11", 64'(stall), 64'd0);
            if (i == 11) chk("t4_stall_at12", 64'(stall), 64'd1);
        end
        chk("t4_full_overflow", 64'(overflow),  64'd0);
        chk("t4_full_valid",    64'(out_valid), 64'd1);
        chk("t4_full_head",     64'(out_data),  64'd100);
        out_ready = 1'b1;
        feed(3, DW'(116));
        chk("t4_pushpop_overflow", 64'(overflow), 64'd0);
        chk("t4_pushpop_head",     64'(out_data), 64'd101);
        out_ready = 1'b0;
        feed(3, DW'(117));
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_stall",    64'(stall),    64'd1);
        out_ready = 1'b1;
        idle(17);
        chk("t4_drained", 64'(out_valid), 64'd0);
        feed(3, DW'(118));
        chk("t4_done3", 64'(done[3]), 64'd1);
        idle(2);
        for (int v = 100; v <= 116; v++) begin
            exp_d.push_back(DW'(v));
            exp_l.push_back(1'b0);
        end
        exp_d.push_back(16'd118);
        exp_l.push_back(1'b1);
        chk_caps("t4");
        chk("t4_all_done", 64'(all_done), 64'd1);

        // Threads 0/7 interleaved, then reset mid-stream.
        out_ready = 1'b0;
        cfg(0, 1'b1, 64'd2);
        cfg(7, 1'b1, 64'd2);
        feed(0, DW'(200));
        feed(7, DW'(700));
        feed(0, DW'(201));
        chk("t5_pre_valid",  64'(out_valid),  64'd1);
        chk("t5_pre_thread", 64'(out_thread), 64'd0);
        chk("t5_pre_data",   64'(out_data),   64'd200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_valid",    64'(out_valid), 64'd0);
        chk("t5_rst_done",     64'(done),      64'd0);
        chk("t5_rst_all_done", 64'(all_done),  64'd0);
        chk("t5_rst_overflow", 64'(overflow),  64'd0);
        chk("t5_rst_stall",    64'(stall),     64'd0);
        // Re-arm thread 7 while a same-thread input collides: the input is dropped.
        out_ready = 1'b1;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_thread = TW'(7); cfg_data = 64'd2;
        en = 1'b1; in_valid = 1'b1; in_thread = TW'(7); in_data = DW'(799);
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        feed(7, DW'(710));
        feed(7, DW'(711));
        idle(3);
        exp_d = '{16'd710, 16'd711};
        exp_l = '{1'b0, 1'b1};
        chk_caps("t5");
        chk("t5_done",     64'(done),     64'h80);
        chk("t5_all_done", 64'(all_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
